// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: round-robin valid/ready arbiter sharing one write-first single-port RAM among NUM_REQ requesters
// Optional SPRAM_ARB_RSP_REG_EN adds a registered response stage (read latency 2 instead of 1).
module spram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_din,
  input  logic [DATA_WIDTH-1:0]          ram_dout,
  output logic                           busy
);
  logic [ID_WIDTH-1:0]   rr_ptr, gnt_id, scan_id, pend_id;
  logic                  gnt_any, pend_valid, rd_acc;
  logic [NUM_REQ-1:0]    pend_oh;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // Descending scan so the last hit is the nearest requester at or after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_id = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[scan_id]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_id;
      end
    end
  end
  assign req_ready = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
  assign ram_we    = gnt_any & req_we[gnt_id];
  assign ram_addr  = gnt_any ? addr_a[gnt_id] : '0;
  assign ram_din   = gnt_any ? data_a[gnt_id] : '0;
  assign rd_acc    = gnt_any & ~req_we[gnt_id];
  assign pend_oh   = pend_valid ? NUM_REQ'(1) << pend_id : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_id == ID_WIDTH'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      pend_valid <= rd_acc;
      if (rd_acc) pend_id <= gnt_id;
    end
  end
`ifdef SPRAM_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0]    rsp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      rdata_q <= '0;
    end else begin
      rsp_q <= pend_oh;
      if (pend_valid) rdata_q <= ram_dout;
    end
  end
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign busy      = pend_valid | (|rsp_q);
`else
  assign rsp_valid = pend_oh;
  assign rsp_rdata = ram_dout;
  assign busy      = pend_valid;
`endif
endmodule
